// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared encodings and stage tag type for the hazard unit
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    // Tag rd field is wide enough for any REG_AW up to 8.
    localparam int TAG_RD_W = 8;

    localparam logic [1:0] CLS_ALU   = 2'd0;
    localparam logic [1:0] CLS_LOAD  = 2'd1;
    localparam logic [1:0] CLS_MUL   = 2'd2;
    localparam logic [1:0] CLS_OTHER = 2'd3;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                is_load;
    } stage_tag_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_fwd_sel.sv
// ============================================================================
// pipeline_fwd_sel : tag match and EX/MEM-over-MEM/WB priority for one source
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_fwd_sel
    import pipeline_pkg::*;
(
    input  logic [TAG_RD_W-1:0] src_i,
    input  logic                used_i,
    input  logic                ex_valid_i,
    input  logic [TAG_RD_W-1:0] ex_rd_i,
    input  logic                mem_valid_i,
    input  logic [TAG_RD_W-1:0] mem_rd_i,
    output logic                match_ex_o,
    output logic                match_mem_o,
    output logic [1:0]          sel_o
);

    always_comb begin
        match_ex_o  = ex_valid_i  & used_i & (ex_rd_i  == src_i);
        match_mem_o = mem_valid_i & used_i & (mem_rd_i == src_i);
        if (match_ex_o) begin
            sel_o = FWD_EXMEM;
        end else if (match_mem_o) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
// ============================================================================
// pipeline_hazard_unit : stall, forwarding-select, multiplier-hold and flush
// control for the five-stage pipeline.  Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int FWD_ENABLE = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wr,
    input  logic [1:0]        id_class,
    input  logic              id_redirect,
    output logic              stall,
    output logic              ex_hold,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int              MC_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_CYCLES - 1);

    stage_tag_t       ex_tag_q, ex_tag_d, mem_tag_q, mem_tag_d, wb_tag_q;
    logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_count_q;

    logic       match_ex_a, match_mem_a, match_ex_b, match_mem_b;
    logic [1:0] sel_a, sel_b;
    logic       stall_cause, issue;

    pipeline_fwd_sel u_sel_a (
        .src_i       (TAG_RD_W'(id_rs1)),
        .used_i      (id_rs1_used),
        .ex_valid_i  (ex_tag_q.valid),
        .ex_rd_i     (ex_tag_q.rd),
        .mem_valid_i (mem_tag_q.valid),
        .mem_rd_i    (mem_tag_q.rd),
        .match_ex_o  (match_ex_a),
        .match_mem_o (match_mem_a),
        .sel_o       (sel_a)
    );

    pipeline_fwd_sel u_sel_b (
        .src_i       (TAG_RD_W'(id_rs2)),
        .used_i      (id_rs2_used),
        .ex_valid_i  (ex_tag_q.valid),
        .ex_rd_i     (ex_tag_q.rd),
        .mem_valid_i (mem_tag_q.valid),
        .mem_rd_i    (mem_tag_q.rd),
        .match_ex_o  (match_ex_b),
        .match_mem_o (match_mem_b),
        .sel_o       (sel_b)
    );

    always_comb begin
        ex_hold = (mul_cnt_q != '0);
        if (FWD_ENABLE != 0) begin
            stall_cause = ex_tag_q.is_load & (match_ex_a | match_ex_b);
        end else begin
            stall_cause = match_ex_a | match_ex_b | match_mem_a | match_mem_b;
        end
        stall      = id_valid & (stall_cause | ex_hold);
        issue      = id_valid & ~stall;
        flush_ifid = id_valid & id_redirect & ~stall;
    end

    always_comb begin
        ex_tag_d  = '0;
        mem_tag_d = ex_tag_q;
        fwd_a_d   = FWD_RF;
        fwd_b_d   = FWD_RF;
        mul_cnt_d = mul_cnt_q;
        if (ex_hold) begin
            // Multiplier occupies EX: freeze EX contents, drain a bubble to MEM.
            ex_tag_d  = ex_tag_q;
            mem_tag_d = '0;
            fwd_a_d   = fwd_a_q;
            fwd_b_d   = fwd_b_q;
            mul_cnt_d = mul_cnt_q - MC_W'(1);
        end else if (issue) begin
            ex_tag_d.valid   = id_rd_wr & (id_rd != '0);
            ex_tag_d.rd      = TAG_RD_W'(id_rd);
            ex_tag_d.is_load = (id_class == CLS_LOAD);
            if (FWD_ENABLE != 0) begin
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end
            if (id_class == CLS_MUL) begin
                mul_cnt_d = MUL_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_tag_q      <= '0;
            mem_tag_q     <= '0;
            wb_tag_q      <= '0;
            mul_cnt_q     <= '0;
            fwd_a_q       <= FWD_RF;
            fwd_b_q       <= FWD_RF;
            stall_count_q <= '0;
        end else begin
            ex_tag_q      <= ex_tag_d;
            mem_tag_q     <= mem_tag_d;
            wb_tag_q      <= mem_tag_q;
            mul_cnt_q     <= mul_cnt_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_q + CNT_W'(stall);
        end
    end

    // The WB tag never stalls or forwards: the register file is write-first.
    logic wb_tag_unused;
    assign wb_tag_unused = ^wb_tag_q;

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
// ============================================================================
// tb_pipeline_hazard_unit : random + directed bench for two hazard-unit builds
// (forwarding on / 32-bit counter, forwarding off / 8-bit counter).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_unit;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_class;

    logic        stall0, hold0, flush0, stall1, hold1, flush1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [31:0] cnt0;
    logic [7:0]  cnt1;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_AW(5), .MUL_CYCLES(MC), .FWD_ENABLE(1), .CNT_W(32)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wr(id_rd_wr), .id_class(id_class), .id_redirect(id_redirect),
        .stall(stall0), .ex_hold(hold0), .flush_ifid(flush0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_count(cnt0)
    );

    pipeline_hazard_unit #(.REG_AW(5), .MUL_CYCLES(MC), .FWD_ENABLE(0), .CNT_W(8)) u_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wr(id_rd_wr), .id_class(id_class), .id_redirect(id_redirect),
        .stall(stall1), .ex_hold(hold1), .flush_ifid(flush1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_count(cnt1)
    );

    // Reference model: per build, the two in-flight producers ahead of ID
    // (index 0 = in EX, 1 = in MEM), cycles of multiply left, pending selects.
    bit    m_ev[2][2];
    int    m_rd[2][2];
    bit    m_ld[2][2];
    int    m_mul[2];
    int    m_fa[2], m_fb[2];
    longint m_cnt[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input int k);
        bit fwd_on;
        bit mae, mbe, mam, mbm, cause, hold, st, iss, fl;
        int sa, sb;
        longint modulus;
        fwd_on  = (k == 0);
        modulus = (k == 0) ? (longint'(1) << 32) : 256;
        mae = m_ev[k][0] && id_rs1_used && (m_rd[k][0] == int'(id_rs1));
        mbe = m_ev[k][0] && id_rs2_used && (m_rd[k][0] == int'(id_rs2));
        mam = m_ev[k][1] && id_rs1_used && (m_rd[k][1] == int'(id_rs1));
        mbm = m_ev[k][1] && id_rs2_used && (m_rd[k][1] == int'(id_rs2));
        hold  = (m_mul[k] > 0);
        cause = fwd_on ? ((mae || mbe) && m_ld[k][0]) : (mae || mbe || mam || mbm);
        st  = id_valid && (cause || hold);
        iss = id_valid && !st;
        fl  = iss && id_redirect;
        sa  = mae ? 1 : (mam ? 2 : 0);
        sb  = mbe ? 1 : (mbm ? 2 : 0);

        chk($sformatf("stall[%0d]", k), (k == 0) ? stall0 : stall1, st);
        chk($sformatf("ex_hold[%0d]", k), (k == 0) ? hold0 : hold1, hold);
        chk($sformatf("flush[%0d]", k), (k == 0) ? flush0 : flush1, fl);
        chk($sformatf("fwd_a[%0d]", k), (k == 0) ? fa0 : fa1, m_fa[k]);
        chk($sformatf("fwd_b[%0d]", k), (k == 0) ? fb0 : fb1, m_fb[k]);
        chk($sformatf("stall_count[%0d]", k), (k == 0) ? {32'b0, cnt0} : {56'b0, cnt1}, m_cnt[k]);

        if (reset) begin
            m_ev[k][0] = 0; m_ev[k][1] = 0;
            m_mul[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_cnt[k] = 0;
        end else begin
            if (hold) begin
                m_ev[k][1] = 0;
                m_mul[k]--;
            end else begin
                m_ev[k][1] = m_ev[k][0];
                m_rd[k][1] = m_rd[k][0];
                m_ld[k][1] = m_ld[k][0];
                if (iss) begin
                    m_ev[k][0] = id_rd_wr && (id_rd != 0);
                    m_rd[k][0] = int'(id_rd);
                    m_ld[k][0] = (id_class == 2'd1);
                    m_fa[k]    = fwd_on ? sa : 0;
                    m_fb[k]    = fwd_on ? sb : 0;
                    m_mul[k]   = (id_class == 2'd2) ? MC - 1 : 0;
                end else begin
                    m_ev[k][0] = 0;
                    m_fa[k] = 0;
                    m_fb[k] = 0;
                end
            end
            m_cnt[k] = (m_cnt[k] + longint'(st)) % modulus;
        end
    endtask

    // Drive one cycle of ID contents just after the edge, check at the falling
    // edge, then advance the model to what the next rising edge will produce.
    task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wr, input int cls, input bit rdr, input bit rst);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_rs1_used = u1; id_rs2_used = u2; id_rd = 5'(rd); id_rd_wr = wr;
        id_class = 2'(cls); id_redirect = rdr; reset = rst;
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
        id_rs2_used = 0; id_rd = 0; id_rd_wr = 0; id_class = 0; id_redirect = 0;
        for (int k = 0; k < 2; k++) begin
            m_ev[k][0] = 0; m_ev[k][1] = 0; m_rd[k][0] = 0; m_rd[k][1] = 0;
            m_ld[k][0] = 0; m_ld[k][1] = 0; m_mul[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);

        idle(1);
        chk("rst_stall", stall0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_fwd_a", fa0, 0);

        // LOAD r3 ; ADD r4,r3,r5
        step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        step(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        chk("lu_stall", stall0, 1);
        step(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        chk("lu_issue", stall0, 0);
        chk("nf_stall2", stall1, 1);
        idle(1);
        chk("lu_fwd_a", fa0, 2);
        chk("lu_cnt", cnt0, 1);
        chk("nf_cnt", cnt1, 2);
        idle(3);

        // ADD r3 ; SUB r6,r3,r3  then with one NOP between
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(1, 3, 3, 1, 1, 6, 1, 0, 0, 0);
        chk("alu_nostall", stall0, 0);
        idle(1);
        chk("alu_fa1", fa0, 1);
        chk("alu_fb1", fb0, 1);
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        idle(1);
        step(1, 3, 3, 1, 1, 6, 1, 0, 0, 0);
        idle(1);
        chk("nop_fa2", fa0, 2);
        chk("nop_fb2", fb0, 2);
        idle(3);

        // MUL r7 ; ADD r8,r7,r1
        step(1, 1, 2, 1, 1, 7, 1, 2, 0, 0);
        for (int i = 0; i < MC - 1; i++) begin
            step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
            chk("mul_hold", hold0, 1);
            chk("mul_stall", stall0, 1);
        end
        step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        chk("mul_done", hold0, 0);
        chk("mul_issue", stall0, 0);
        idle(1);
        chk("mul_fa1", fa0, 1);
        idle(3);

        // Taken branch, then branch on a just-loaded register
        step(1, 9, 0, 1, 0, 0, 0, 3, 1, 0);
        chk("br_flush", flush0, 1);
        step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 3, 1, 0);
        chk("br_delay", flush0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 3, 1, 0);
        chk("br_late", flush0, 1);
        idle(3);

        // Reset on the second hold cycle of a multiply
        step(1, 1, 2, 1, 1, 7, 1, 2, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
        chk("rmul_hold", hold0, 0);
        chk("rmul_stall", stall0, 0);
        chk("rmul_cnt", cnt0, 0);
        idle(1);
        chk("rmul_fa", fa0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard, forwarding and multi-cycle-execute controller for the five-stage pipelined processor (IF, ID, EX, MEM, WB). It sits between the control unit and the datapath and replaces the single `stall` line with three things: load-use and no-forwarding stalls, registered EX-stage operand forwarding selects, and a structural hold for a multi-cycle multiplier. It tracks in-flight destination registers in an internal EX/MEM/WB tag pipeline and also drives the IF/ID flush on taken branches and jumps resolved in ID.

## Interface
Parameters:
- `REG_AW`, 5: register-address width.
- `MUL_CYCLES`, 4: EX occupancy of a MUL-class op; must be ≥1.
- `FWD_ENABLE`, 1: 1 = forward from MEM/WB; 0 = stall until the producer reaches WB.
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in REG_AW: source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in REG_AW: destination register.
- `id_rd_wr` in 1: the instruction writes `id_rd`.
- `id_class` in 2: 0 ALU, 1 LOAD, 2 MUL, 3 OTHER.
- `id_redirect` in 1: taken branch or jump resolved in ID.
- `stall` out 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `ex_hold` out 1: multiplier busy; hold ID/EX and EX, bubble into EX/MEM.
- `flush_ifid` out 1: squash IF/ID.
- `fwd_a`, `fwd_b` out 2: EX operand select; 0 register file, 1 EX/MEM, 2 MEM/WB.
- `stall_count` out CNT_W: number of cycles in which `stall` was high.

## Operation
- Tag pipeline: `ex_tag`, `mem_tag` and `wb_tag` each hold {valid, rd, is_load}.
  - A tag is valid only when rd≠0 and `id_rd_wr` was set.
  - Register 0 never creates a hazard.
- A source *matches* a tag when the tag is valid, the source is used, and the source equals the tag's rd.
- Stall causes:
  - FWD_ENABLE=1: a source matches `ex_tag` and `ex_tag.is_load` is set (load-use).
  - FWD_ENABLE=0: a source matches `ex_tag` or `mem_tag`.
  - Either mode: `ex_hold` is high.
- `stall` = `id_valid` & (any stall cause).
- The register file is write-first, so a match on `wb_tag` never stalls.
- Issue = `id_valid` & !`stall`.
- `ex_tag` update:
  - On issue: loaded from the ID fields.
  - On stall without hold: cleared to a bubble.
  - On `ex_hold`: held.
- `mem_tag` update: loads from `ex_tag`, or a bubble if `ex_hold` is high. `wb_tag` always loads from `mem_tag`.
- Forwarding (FWD_ENABLE=1):
  - `fwd_a`/`fwd_b` are computed in ID and registered on issue.
  - Select 1 if the source matches `ex_tag` (the producer will be in MEM); else 2 if it matches `mem_tag`; else 0. EX/MEM has priority.
  - A bubble clears both selects to 0. During `ex_hold` the selects are held.
  - FWD_ENABLE=0: both selects are tied to 0.
- Multiplier counter `mul_cnt`:
  - Loaded with MUL_CYCLES−1 when a MUL-class op issues.
  - Decrements while nonzero.
  - `ex_hold` = (`mul_cnt`≠0).
  - With MUL_CYCLES=1, `ex_hold` never asserts.
- Flush: `flush_ifid` = `id_valid` & `id_redirect` & !`stall`. A redirect whose operands are not ready waits until its stall clears.
- `stall_count` increments each cycle `stall` is high and wraps modulo 2^CNT_W.

## Timing
- `stall`, `flush_ifid` and `ex_hold` are combinational from inputs and state, valid in the same cycle.
- `fwd_a`/`fwd_b` are registered and valid during the cycle the consumer is in EX.
- Load-use costs exactly 1 stall cycle. A MUL costs MUL_CYCLES−1 hold cycles.
- Reset (takes effect on the next rising edge, including mid-multiply):
  - All tags become invalid, `mul_cnt`=0, `fwd_a`=`fwd_b`=0, `stall_count`=0.
  - So `stall`=`ex_hold`=`flush_ifid`=0 after reset.
- Simultaneous events:
  - Stall plus redirect: the stall wins and no flush occurs.
  - Hold plus load-use: `stall` stays high and `ex_tag` is held; the load-use is re-evaluated after the hold ends.

## Structure
- Shared package `pipeline_pkg` holds:
  - The `id_class` encoding: `CLS_ALU`, `CLS_LOAD`, `CLS_MUL`, `CLS_OTHER`.
  - The forward-select constants: `FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`.
  - The stage tag struct `stage_tag_t`.
- One sub-module, `pipeline_fwd_sel`: combinational match and priority for one source operand, instantiated twice.

## Test plan
- LOAD r3 then ADD r4,r3,r5 (FWD_ENABLE=1) -> `stall`=1 for exactly 1 cycle, then ADD enters EX with `fwd_a`=2; `stall_count`=1.
- ADD r3 then SUB r6,r3,r3 -> no stall, `fwd_a`=`fwd_b`=1; insert one NOP between them -> both selects =2.
- MUL r7 (MUL_CYCLES=4) followed by ADD r8,r7,r1 -> `ex_hold`=1 for 3 cycles, ADD stalled throughout, then `fwd_a`=1.
- FWD_ENABLE=0, ADD r2 then ADD r9,r2,r2 -> `stall` for 2 cycles, selects stay 0.
- Taken BEQZ in ID with no hazard -> `flush_ifid`=1 for one cycle; BEQZ r3 directly after LOAD r3 -> flush delayed by 1 cycle.
- Assert `reset` on the 2nd cycle of a MUL hold -> next cycle `ex_hold`=0, `stall`=0, all tags invalid, `stall_count`=0.
